// File: rtl/axi4lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_pkg
// Description : Shared constants and FSM state types for the AXI4-Lite
//               register-bank responder.
//               - C_RESP_OKAY / C_RESP_SLVERR : AXI response codes
//               - t_wr_state                  : write-channel FSM states
//               - t_rd_state                  : read-channel FSM states
// Revision    : 1.0 - initial release
// ============================================================================
package axi4lite_pkg;

    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_WAIT_W  = 2'd1,
        W_WAIT_AW = 2'd2,
        W_RESP    = 2'd3
    } t_wr_state;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } t_rd_state;

endpackage
`default_nettype wire

// File: rtl/axi4lite_slave_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_slave_regs_if
// Description : AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//               modport master : drives valids/addresses/data, bready, rready
//               modport slave  : drives readys, bvalid/bresp, rvalid/rdata/rresp
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4lite_slave_regs_if #(
    parameter int G_AXI4_LITE_ADDR_WIDTH = 32,
    parameter int G_AXI4_LITE_DATA_WIDTH = 32
) ();

    logic                                  awvalid;
    logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                            awprot;
    logic                                  awready;

    logic                                  wvalid;
    logic [G_AXI4_LITE_DATA_WIDTH-1:0]     wdata;
    logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]   wstrb;
    logic                                  wready;

    logic                                  bvalid;
    logic                                  bready;
    logic [1:0]                            bresp;

    logic                                  arvalid;
    logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                            arprot;
    logic                                  arready;

    logic                                  rvalid;
    logic                                  rready;
    logic [G_AXI4_LITE_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                            rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface
`default_nettype wire

// File: rtl/axi4lite_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_slave_regfile
// Description : Bank of G_NB_REGS registers with a byte-strobed write port,
//               a one-cycle write pulse per register and a combinational
//               read mux.
//   clk, rst      : clock, synchronous active-high reset
//   i_wr_en       : write the register selected by i_wr_idx this edge
//   i_wr_idx      : write register index
//   i_wr_data     : write data
//   i_wr_strb     : per-byte write enables
//   i_rd_idx      : read register index
//   o_rd_data     : selected register value (0 for an unmapped index)
//   o_regs        : flattened contents, reg i at [i*DW +: DW]
//   o_wr_pulse    : bit i high for the cycle reg i first shows a new write
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_slave_regfile #(
    parameter int G_DATA_WIDTH = 32,
    parameter int G_NB_REGS    = 16,
    parameter int G_IDX_WIDTH  = 4
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              i_wr_en,
    input  wire logic [G_IDX_WIDTH-1:0]            i_wr_idx,
    input  wire logic [G_DATA_WIDTH-1:0]           i_wr_data,
    input  wire logic [G_DATA_WIDTH/8-1:0]         i_wr_strb,
    input  wire logic [G_IDX_WIDTH-1:0]            i_rd_idx,
    output logic      [G_DATA_WIDTH-1:0]           o_rd_data,
    output logic      [G_NB_REGS*G_DATA_WIDTH-1:0] o_regs,
    output logic      [G_NB_REGS-1:0]              o_wr_pulse
);

    localparam int c_strb_w = G_DATA_WIDTH / 8;

    logic [G_NB_REGS*G_DATA_WIDTH-1:0] w_regs;

    for (genvar i = 0; i < G_NB_REGS; i++) begin : g_reg
        logic                    w_sel;
        logic [G_DATA_WIDTH-1:0] r_reg;
        logic                    r_pulse;

        assign w_sel = i_wr_en && (i_wr_idx == G_IDX_WIDTH'(i));

        // The pulse is registered on the same edge as the data so both
        // become visible together.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_reg   <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= w_sel;
                if (w_sel) begin
                    for (int b = 0; b < c_strb_w; b++) begin
                        if (i_wr_strb[b]) begin
                            r_reg[8*b +: 8] <= i_wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end

        assign w_regs[i*G_DATA_WIDTH +: G_DATA_WIDTH] = r_reg;
        assign o_wr_pulse[i]                          = r_pulse;
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < G_NB_REGS; i++) begin
            if (i_rd_idx == G_IDX_WIDTH'(i)) begin
                o_rd_data = w_regs[i*G_DATA_WIDTH +: G_DATA_WIDTH];
            end
        end
    end

    assign o_regs = w_regs;

endmodule
`default_nettype wire

// File: rtl/axi4lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_slave_regs
// Description : AXI4-Lite responder exposing G_NB_REGS 32-bit registers at
//               word-aligned byte addresses from 0. Write and read channels
//               run independent FSMs; unmapped indices answer SLVERR.
//   clk, rst  : clock, synchronous active-high reset
//   axi       : AXI4-Lite slave port (awprot/arprot ignored)
//   regs_out  : flattened register contents, reg i at [i*32 +: 32]
//   wr_pulse  : one-cycle pulse per register, aligned with the new value
// Only a 32-bit data width is supported.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_slave_regs
    import axi4lite_pkg::*;
#(
    parameter int G_AXI4_LITE_ADDR_WIDTH = 32,
    parameter int G_AXI4_LITE_DATA_WIDTH = 32,
    parameter int G_NB_REGS              = 16
) (
    input  wire logic                                         clk,
    input  wire logic                                         rst,
    axi4lite_slave_regs_if.slave                              axi,
    output logic [G_NB_REGS*G_AXI4_LITE_DATA_WIDTH-1:0]       regs_out,
    output logic [G_NB_REGS-1:0]                              wr_pulse
);

    localparam int c_aw     = G_AXI4_LITE_ADDR_WIDTH;
    localparam int c_dw     = G_AXI4_LITE_DATA_WIDTH;
    localparam int c_strb_w = c_dw / 8;
    localparam int c_full_w = c_aw - 2;
    localparam int c_idx_w  = (G_NB_REGS > 1) ? $clog2(G_NB_REGS) : 1;
    localparam logic [c_full_w-1:0] c_nb_regs = c_full_w'(G_NB_REGS);

    // Held low through reset and the first cycle after it so that no
    // handshake can be taken while the bank is still coming out of reset.
    logic r_init;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    t_wr_state             r_wstate;
    t_wr_state             w_wstate_nxt;
    logic                  w_aw_fire;
    logic                  w_w_fire;
    logic                  w_wr_go;
    logic                  w_wr_hit;
    logic [c_full_w-1:0]   w_aw_idx;
    logic [c_full_w-1:0]   r_aw_idx;
    logic [c_full_w-1:0]   w_wr_idx;
    logic [c_dw-1:0]       r_wdata;
    logic [c_dw-1:0]       w_wr_data;
    logic [c_strb_w-1:0]   r_wstrb;
    logic [c_strb_w-1:0]   w_wr_strb;
    logic [1:0]            r_bresp;

    assign axi.awready = r_init & ~rst & ((r_wstate == W_IDLE) || (r_wstate == W_WAIT_AW));
    assign axi.wready  = r_init & ~rst & ((r_wstate == W_IDLE) || (r_wstate == W_WAIT_W));
    assign axi.bvalid  = (r_wstate == W_RESP);
    assign axi.bresp   = r_bresp;

    assign w_aw_fire = axi.awvalid & axi.awready;
    assign w_w_fire  = axi.wvalid  & axi.wready;
    assign w_aw_idx  = axi.awaddr[c_aw-1:2];

    // A half that arrived earlier comes from its latch; the other half is
    // taken straight off the bus in the completing cycle.
    assign w_wr_idx  = (r_wstate == W_WAIT_W)  ? r_aw_idx : w_aw_idx;
    assign w_wr_data = (r_wstate == W_WAIT_AW) ? r_wdata  : axi.wdata;
    assign w_wr_strb = (r_wstate == W_WAIT_AW) ? r_wstrb  : axi.wstrb;
    assign w_wr_hit  = (w_wr_idx < c_nb_regs);

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wr_go      = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_fire && w_w_fire) begin
                    w_wstate_nxt = W_RESP;
                    w_wr_go      = 1'b1;
                end else if (w_aw_fire) begin
                    w_wstate_nxt = W_WAIT_W;
                end else if (w_w_fire) begin
                    w_wstate_nxt = W_WAIT_AW;
                end
            end
            W_WAIT_W: begin
                if (w_w_fire) begin
                    w_wstate_nxt = W_RESP;
                    w_wr_go      = 1'b1;
                end
            end
            W_WAIT_AW: begin
                if (w_aw_fire) begin
                    w_wstate_nxt = W_RESP;
                    w_wr_go      = 1'b1;
                end
            end
            W_RESP: begin
                if (axi.bready) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_init   <= 1'b0;
            r_wstate <= W_IDLE;
            r_aw_idx <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= C_RESP_OKAY;
        end else begin
            r_init   <= 1'b1;
            r_wstate <= w_wstate_nxt;
            if (w_aw_fire) begin
                r_aw_idx <= w_aw_idx;
            end
            if (w_w_fire) begin
                r_wdata <= axi.wdata;
                r_wstrb <= axi.wstrb;
            end
            if (w_wr_go) begin
                r_bresp <= w_wr_hit ? C_RESP_OKAY : C_RESP_SLVERR;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    t_rd_state             r_rstate;
    t_rd_state             w_rstate_nxt;
    logic                  w_ar_fire;
    logic                  w_ar_hit;
    logic [c_full_w-1:0]   w_ar_idx;
    logic [c_dw-1:0]       w_rd_word;
    logic [c_dw-1:0]       r_rdata;
    logic [1:0]            r_rresp;

    assign axi.arready = r_init & ~rst & (r_rstate == R_IDLE);
    assign axi.rvalid  = (r_rstate == R_DATA);
    assign axi.rdata   = r_rdata;
    assign axi.rresp   = r_rresp;

    assign w_ar_fire = axi.arvalid & axi.arready;
    assign w_ar_idx  = axi.araddr[c_aw-1:2];
    assign w_ar_hit  = (w_ar_idx < c_nb_regs);

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_fire)  w_rstate_nxt = R_DATA;
            R_DATA:  if (axi.rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Sampling the mux on the handshake edge means a write landing on the
    // same edge is not yet visible: the read returns the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= C_RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_fire) begin
                r_rdata <= w_ar_hit ? w_rd_word : '0;
                r_rresp <= w_ar_hit ? C_RESP_OKAY : C_RESP_SLVERR;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    axi4lite_slave_regfile #(
        .G_DATA_WIDTH (c_dw),
        .G_NB_REGS    (G_NB_REGS),
        .G_IDX_WIDTH  (c_idx_w)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_wr_go & w_wr_hit),
        .i_wr_idx   (w_wr_idx[c_idx_w-1:0]),
        .i_wr_data  (w_wr_data),
        .i_wr_strb  (w_wr_strb),
        .i_rd_idx   (w_ar_idx[c_idx_w-1:0]),
        .o_rd_data  (w_rd_word),
        .o_regs     (regs_out),
        .o_wr_pulse (wr_pulse)
    );

    logic w_unused;
    assign w_unused = ^{axi.awprot, axi.arprot, axi.awaddr[1:0], axi.araddr[1:0]};

endmodule
`default_nettype wire
